// File: rtl/seg7_scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_pkg
// Shared definitions for the 7-segment scan decoder:
//   - active-low glyph table (hex 0..F plus blank), bit 6 = g ... bit 0 = a;
//     the hex encoder imports the same constants so both ends agree
//   - stability FSM state encoding
//   - select-line helper function
// ---------------------------------------------------------------------------
package seg7_scan_decoder_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h18;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_HELD   = 1'b1
  } scan_state_t;

  // Number of low (active) lines in a select vector padded to 8 bits with ones.
  function automatic logic [3:0] count_low8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!v[i]) n = n + 4'd1;
      else       n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Purely combinational glyph decoder for an active-low 7-segment pattern.
// Ports:
//   pattern in  [6:0] : active-low segments, bit 6 = g ... bit 0 = a
//   nibble  out [3:0] : hex value of a legal glyph (0 otherwise)
//   legal   out       : pattern is one of the 16 hex glyphs
//   blank   out       : pattern is all segments off
// ---------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  // Glyph table lookup; anything not in the table is neither legal nor blank.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (pattern)
      GLYPH_0:     nibble = 4'h0;
      GLYPH_1:     nibble = 4'h1;
      GLYPH_2:     nibble = 4'h2;
      GLYPH_3:     nibble = 4'h3;
      GLYPH_4:     nibble = 4'h4;
      GLYPH_5:     nibble = 4'h5;
      GLYPH_6:     nibble = 4'h6;
      GLYPH_7:     nibble = 4'h7;
      GLYPH_8:     nibble = 4'h8;
      GLYPH_9:     nibble = 4'h9;
      GLYPH_A:     nibble = 4'hA;
      GLYPH_B:     nibble = 4'hB;
      GLYPH_C:     nibble = 4'hC;
      GLYPH_D:     nibble = 4'hD;
      GLYPH_E:     nibble = 4'hE;
      GLYPH_F:     nibble = 4'hF;
      GLYPH_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Watches a multiplexed active-low 7-segment bus, waits for each digit's
// (segments, select) pair to be stable for STABLE_CYCLES samples, decodes
// the glyph and publishes a coherent frame once every digit was captured.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   seg [6:0]          : active-low segments (bit 6 = g ... bit 0 = a)
//   digit_sel          : active-low digit selects, one-hot-low when valid
//   digit_value        : live decoded nibble per digit, digit i at [4i+3:4i]
//   digit_valid        : last capture of digit i was a legal hex glyph
//   frame_value        : snapshot of digit_value when all digits captured
//   frame_stb          : one-cycle pulse when frame_value updates
//   pattern_err        : one-cycle pulse on capture of an illegal pattern
//   sel_err            : one-cycle pulse when multiple selects first go low
// ---------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   digit_value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [4*DIGITS-1:0]   frame_value,
  output logic                  frame_stb,
  output logic                  pattern_err,
  output logic                  sel_err
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_PRE = CW'(STABLE_CYCLES - 1);

  logic [6:0]           seg_r, seg_prev_r;
  logic [DIGITS-1:0]    sel_r, sel_prev_r;
  logic [CW-1:0]        cnt_r, cnt_next_s;
  scan_state_t          state_r, state_next_s;
  logic [4*DIGITS-1:0]  value_r, value_next_s, frame_r;
  logic [DIGITS-1:0]    valid_r, valid_next_s, mask_r, mask_next_s;
  logic                 frame_stb_r, pattern_err_r, sel_err_r;

  logic [7:0]           sel_pad_s, sel_prev_pad_s;
  logic                 one_low_s, multi_s, multi_prev_s, same_s;
  logic                 capture_s, perr_next_s, frame_done_s;
  logic [3:0]           nibble_s;
  logic                 legal_s, blank_s;

  seg7_pattern_decode u_decode (
    .pattern (seg_r),
    .nibble  (nibble_s),
    .legal   (legal_s),
    .blank   (blank_s)
  );

  // Select classification; unused upper lanes are padded as inactive (high).
  always_comb begin
    sel_pad_s                   = 8'hFF;
    sel_pad_s[DIGITS-1:0]       = sel_r;
    sel_prev_pad_s              = 8'hFF;
    sel_prev_pad_s[DIGITS-1:0]  = sel_prev_r;
    one_low_s    = (count_low8(sel_pad_s) == 4'd1);
    multi_s      = (count_low8(sel_pad_s) > 4'd1);
    multi_prev_s = (count_low8(sel_prev_pad_s) > 4'd1);
    same_s       = (seg_r == seg_prev_r) && (sel_r == sel_prev_r);
  end

  // Input stage plus one-sample history used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r      <= GLYPH_BLANK;
      sel_r      <= {DIGITS{1'b1}};
      seg_prev_r <= GLYPH_BLANK;
      sel_prev_r <= {DIGITS{1'b1}};
    end else begin
      seg_r      <= seg;
      sel_r      <= digit_sel;
      seg_prev_r <= seg_r;
      sel_prev_r <= sel_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_SETTLE;
    else       state_r <= state_next_s;
  end

  // FSM next state: HELD blocks recapture until the pair changes or goes invalid.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_SETTLE: begin
        if (capture_s) state_next_s = ST_HELD;
        else           state_next_s = ST_SETTLE;
      end
      ST_HELD: begin
        if (!same_s || !one_low_s) state_next_s = ST_SETTLE;
        else                       state_next_s = ST_HELD;
      end
      default: state_next_s = ST_SETTLE;
    endcase
  end

  // FSM outputs: stability count (saturating) and the capture strobe.
  always_comb begin
    if (!one_low_s)            cnt_next_s = {CW{1'b0}};
    else if (!same_s)          cnt_next_s = CW'(1);
    else if (cnt_r == CNT_MAX) cnt_next_s = cnt_r;
    else                       cnt_next_s = cnt_r + CW'(1);
    capture_s = (state_r == ST_SETTLE) && one_low_s && same_s && (cnt_r == CNT_PRE);
  end

  // Stability counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_r <= {CW{1'b0}};
    else       cnt_r <= cnt_next_s;
  end

  // Capture datapath: update the selected digit and the captured mask.
  always_comb begin
    value_next_s = value_r;
    valid_next_s = valid_r;
    mask_next_s  = mask_r;
    perr_next_s  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (capture_s && !sel_r[i]) begin
        mask_next_s[i] = 1'b1;
        if (legal_s) begin
          value_next_s[4*i +: 4] = nibble_s;
          valid_next_s[i]        = 1'b1;
        end else if (blank_s) begin
          value_next_s[4*i +: 4] = 4'h0;
          valid_next_s[i]        = 1'b0;
        end else begin
          // Illegal glyph keeps the previous nibble but drops validity.
          valid_next_s[i]        = 1'b0;
          perr_next_s            = 1'b1;
        end
      end else begin
        mask_next_s[i] = mask_r[i];
      end
    end
    frame_done_s = capture_s && (&mask_next_s);
  end

  // Output registers; a completing capture snapshots the already-updated digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r       <= {(4*DIGITS){1'b0}};
      valid_r       <= {DIGITS{1'b0}};
      mask_r        <= {DIGITS{1'b0}};
      frame_r       <= {(4*DIGITS){1'b0}};
      frame_stb_r   <= 1'b0;
      pattern_err_r <= 1'b0;
      sel_err_r     <= 1'b0;
    end else begin
      value_r       <= value_next_s;
      valid_r       <= valid_next_s;
      pattern_err_r <= perr_next_s;
      sel_err_r     <= multi_s && !multi_prev_s;
      frame_stb_r   <= frame_done_s;
      if (frame_done_s) begin
        frame_r <= value_next_s;
        mask_r  <= {DIGITS{1'b0}};
      end else begin
        frame_r <= frame_r;
        mask_r  <= mask_next_s;
      end
    end
  end

  assign digit_value = value_r;
  assign digit_valid = valid_r;
  assign frame_value = frame_r;
  assign frame_stb   = frame_stb_r;
  assign pattern_err = pattern_err_r;
  assign sel_err     = sel_err_r;

endmodule
